// File: rtl/cpu_pkg.sv
// Purpose : shared types and sizes for the single-cycle MIPS data-memory loader.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // Loader sequencing: wait for a press, commit one word, then hand off to the CPU.
    typedef enum logic [1:0] {
        LOAD_WAIT = 2'd0,
        LOAD_WR   = 2'd1,
        RUN       = 2'd2
    } load_state_t;

    localparam int DMEM_DEPTH = 10;
    localparam int DMEM_AW    = 4;
    localparam int DW         = 16;

endpackage

// File: rtl/btn_debounce.sv
// Purpose : synchronise a raw bouncing button, accept level changes after
//           DEB_CYCLES stable cycles, and emit a one-cycle pulse on each accepted rise.
// Latency : raw edge first sampled at E -> db at E+DEB_CYCLES+1, press during the next cycle.
// Backpressure: none; every accepted rising level produces exactly one press pulse.
//
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous active-high reset
//   btn   - raw asynchronous button input
//   db    - debounced (accepted) button level
//   press - one-cycle pulse on the accepted rising edge of db
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic db,
    output logic press
);

    localparam int             CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          db_q;

    // Two-flop synchronizer; s2 is the first flop safe to use in logic.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Any return of s2 to the accepted level restarts the count, so only a
    // run of DEB_CYCLES consecutive differing samples changes db.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt  <= '0;
            db   <= 1'b0;
            db_q <= 1'b0;
        end else begin
            db_q <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = db & ~db_q;

endmodule

// File: rtl/dmem_load_ctrl.sv
// Purpose : boot-time loader for the data memory; one word per debounced button
//           press at ascending addresses, then hands the write port to the CPU.
// Latency : write lands DEB_CYCLES+3 edges after the press is first sampled;
//           the CPU store path in RUN is purely combinational.
// Backpressure: none; presses outside LOAD_WAIT and CPU stores during load are dropped.
//
// Ports:
//   clk, clr                      - clock and synchronous active-high reset
//   load_btn, load_data           - raw load button and switch value to commit
//   cpu_mem_write/addr/wdata      - CPU store request (honoured only in RUN)
//   mem_we/waddr/wdata            - memory write port
//   led                           - one-hot load position (MSB = word 0), all ones in RUN
//   cpu_run                       - CPU released to fetch/execute
//   oob_err                       - CPU store to an address at or beyond DEPTH this cycle
module dmem_load_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH      = cpu_pkg::DMEM_DEPTH,
    parameter int AW         = cpu_pkg::DMEM_AW,
    parameter int DW         = cpu_pkg::DW,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_btn,
    input  logic [DW-1:0]    load_data,
    input  logic             cpu_mem_write,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic             mem_we,
    output logic [AW-1:0]    mem_waddr,
    output logic [DW-1:0]    mem_wdata,
    output logic [DEPTH-1:0] led,
    output logic             cpu_run,
    output logic             oob_err
);

    localparam logic [AW-1:0]    IDX_LAST  = AW'(DEPTH - 1);
    // One bit wider than the address so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0]      ADDR_LIM  = (AW + 1)'(DEPTH);
    localparam logic [DEPTH-1:0] LED_FIRST = {1'b1, {(DEPTH - 1){1'b0}}};

    load_state_t   state;
    load_state_t   state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;
    logic          btn_db;
    logic          press;
    logic          addr_ok;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .clr   (clr),
        .btn   (load_btn),
        .db    (btn_db),
        .press (press)
    );

    assign addr_ok = ({1'b0, cpu_addr} < ADDR_LIM);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= LOAD_WAIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = load_data;
        led       = LED_FIRST >> idx;
        cpu_run   = 1'b0;
        oob_err   = 1'b0;

        case (state)
            LOAD_WAIT: begin
                // press is a rising edge of the accepted level, so both are high together.
                if (press && btn_db) begin
                    state_nxt = LOAD_WR;
                end
            end

            LOAD_WR: begin
                mem_we = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                end else begin
                    state_nxt = LOAD_WAIT;
                    idx_nxt   = idx + AW'(1);
                end
            end

            RUN: begin
                // Out-of-range stores are flagged and dropped rather than aliasing.
                mem_we    = cpu_mem_write & addr_ok;
                mem_waddr = cpu_addr;
                mem_wdata = cpu_wdata;
                led       = '1;
                cpu_run   = 1'b1;
                oob_err   = cpu_mem_write & ~addr_ok;
            end

            default: begin
                state_nxt = LOAD_WAIT;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_load_ctrl.sv
// Purpose : self-checking bench for dmem_load_ctrl with a short debounce window.
// Latency : n/a.
// Backpressure: n/a.
module tb_dmem_load_ctrl;

    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic             load_btn;
    logic [DW-1:0]    load_data;
    logic             cpu_mem_write;
    logic [AW-1:0]    cpu_addr;
    logic [DW-1:0]    cpu_wdata;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [DW-1:0]    mem_wdata;
    logic [DEPTH-1:0] led;
    logic             cpu_run;
    logic             oob_err;

    always #5 clk = ~clk;

    dmem_load_ctrl #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .DW         (DW),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .load_btn      (load_btn),
        .load_data     (load_data),
        .cpu_mem_write (cpu_mem_write),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .led           (led),
        .cpu_run       (cpu_run),
        .oob_err       (oob_err)
    );

    typedef struct {
        logic [DW-1:0]    din;
        logic [AW-1:0]    addr;
        logic [DEPTH-1:0] led;
    } load_vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_we;
        logic [AW-1:0] exp_waddr;
        logic          exp_oob;
    } cpu_vec_t;

    int               compared   = 0;
    int               mismatched = 0;
    int               wr_cnt     = 0;
    logic [AW-1:0]    wr_addr    = '0;
    logic [DW-1:0]    wr_data    = '0;
    logic [DEPTH-1:0] wr_led     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and record any write seen on the memory port.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_we) begin
            wr_cnt++;
            wr_addr = mem_waddr;
            wr_data = mem_wdata;
            wr_led  = led;
        end
    endtask

    // Hold the button for 'hold' cycles then release for 'rel' cycles.
    // k_first is the tick index (1 = first sampling edge) where mem_we first shows.
    task automatic press(input int hold, input int rel, output int k_first);
        k_first  = 0;
        load_btn = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (mem_we && k_first == 0) k_first = k;
        end
        load_btn = 1'b0;
        for (int k = 0; k < rel; k++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        load_vec_t  lv[DEPTH];
        cpu_vec_t   cv[7];
        logic [29:0] pat;
        int          k;

        lv[0] = '{16'h00A0, 4'd0, 10'b1000000000};
        lv[1] = '{16'h00A1, 4'd1, 10'b0100000000};
        lv[2] = '{16'h00A2, 4'd2, 10'b0010000000};
        lv[3] = '{16'h00A3, 4'd3, 10'b0001000000};
        lv[4] = '{16'h00A4, 4'd4, 10'b0000100000};
        lv[5] = '{16'h00A5, 4'd5, 10'b0000010000};
        lv[6] = '{16'h00A6, 4'd6, 10'b0000001000};
        lv[7] = '{16'h00A7, 4'd7, 10'b0000000100};
        lv[8] = '{16'h00A8, 4'd8, 10'b0000000010};
        lv[9] = '{16'h00A9, 4'd9, 10'b0000000001};

        cv[0] = '{1'b1, 4'd3,  16'hBEEF, 1'b1, 4'd3,  1'b0};
        cv[1] = '{1'b1, 4'd12, 16'h1234, 1'b0, 4'd12, 1'b1};
        cv[2] = '{1'b0, 4'd3,  16'hCAFE, 1'b0, 4'd3,  1'b0};
        cv[3] = '{1'b1, 4'd9,  16'h0009, 1'b1, 4'd9,  1'b0};
        cv[4] = '{1'b1, 4'd10, 16'h00AA, 1'b0, 4'd10, 1'b1};
        cv[5] = '{1'b1, 4'd0,  16'h0F0F, 1'b1, 4'd0,  1'b0};
        cv[6] = '{1'b0, 4'd15, 16'hFFFF, 1'b0, 4'd15, 1'b0};

        // Bounce pattern: high runs of at most 3 cycles, separated by short lows.
        pat = 30'b101101110010111011011101011100;

        clr           = 1'b1;
        load_btn      = 1'b0;
        load_data     = '0;
        cpu_mem_write = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;

        // ---- reset ----
        tick();
        tick();
        check("rst_led",     32'(led),       32'(10'b1000000000));
        check("rst_cpu_run", 32'(cpu_run),   32'd0);
        check("rst_mem_we",  32'(mem_we),    32'd0);
        check("rst_waddr",   32'(mem_waddr), 32'd0);
        check("rst_oob",     32'(oob_err),   32'd0);
        clr = 1'b0;
        tick();

        // ---- CPU stores masked during load ----
        cpu_mem_write = 1'b1;
        cpu_addr      = 4'd5;
        cpu_wdata     = 16'h5555;
        #1;
        check("mask_we",    32'(mem_we),    32'd0);
        check("mask_oob",   32'(oob_err),   32'd0);
        check("mask_waddr", 32'(mem_waddr), 32'd0);
        cpu_addr = 4'd12;
        #1;
        check("mask_oob_hi", 32'(oob_err), 32'd0);
        cpu_mem_write = 1'b0;
        cpu_addr      = '0;

        // ---- bounce rejection, then one steady press ----
        wr_cnt    = 0;
        load_data = 16'h5A5A;
        for (int t = 0; t < 30; t++) begin
            load_btn = pat[29 - t];
            tick();
        end
        load_btn = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        check("bounce_no_write", 32'(wr_cnt), 32'd0);
        check("bounce_led",      32'(led),    32'(10'b1000000000));

        load_btn = 1'b1;
        for (int t = 0; t < 6; t++) tick();
        load_btn = 1'b0;
        for (int t = 0; t < 10; t++) tick();
        check("steady_one_write", 32'(wr_cnt),  32'd1);
        check("steady_addr",      32'(wr_addr), 32'd0);
        check("steady_data",      32'(wr_data), 32'h5A5A);

        // ---- reset mid-load after 4 words ----
        for (int w = 1; w < 4; w++) begin
            load_data = 16'h1110 + 16'(w);
            press(8, 8, k);
        end
        check("midload_words", 32'(wr_cnt),  32'd4);
        check("midload_addr",  32'(wr_addr), 32'd3);
        check("midload_led",   32'(led),     32'(10'b0000100000));
        clr = 1'b1;
        tick();
        check("midclr_led",   32'(led),       32'(10'b1000000000));
        check("midclr_waddr", 32'(mem_waddr), 32'd0);
        check("midclr_run",   32'(cpu_run),   32'd0);
        clr = 1'b0;
        tick();

        // ---- clean load of all words, restarting at address 0 ----
        for (int i = 0; i < DEPTH; i++) begin
            load_data = lv[i].din;
            #1;
            check($sformatf("load%0d_led_wait", i), 32'(led), 32'(lv[i].led));
            wr_cnt = 0;
            press(8, 8, k);
            check($sformatf("load%0d_count", i),   32'(wr_cnt),  32'd1);
            check($sformatf("load%0d_latency", i), 32'(k),       32'd7);
            check($sformatf("load%0d_addr", i),    32'(wr_addr), 32'(lv[i].addr));
            check($sformatf("load%0d_data", i),    32'(wr_data), 32'(lv[i].din));
            check($sformatf("load%0d_led_wr", i),  32'(wr_led),  32'(lv[i].led));
        end
        check("run_cpu_run", 32'(cpu_run), 32'd1);
        check("run_led",     32'(led),     32'(10'b1111111111));
        check("run_we_idle", 32'(mem_we),  32'd0);

        // ---- CPU handoff: combinational store path ----
        for (int i = 0; i < 7; i++) begin
            cpu_mem_write = cv[i].we;
            cpu_addr      = cv[i].addr;
            cpu_wdata     = cv[i].wdata;
            #1;
            check($sformatf("cpu%0d_we", i),    32'(mem_we),    32'(cv[i].exp_we));
            check($sformatf("cpu%0d_waddr", i), 32'(mem_waddr), 32'(cv[i].exp_waddr));
            check($sformatf("cpu%0d_wdata", i), 32'(mem_wdata), 32'(cv[i].wdata));
            check($sformatf("cpu%0d_oob", i),   32'(oob_err),   32'(cv[i].exp_oob));
            #1;
        end
        cpu_mem_write = 1'b0;
        cpu_addr      = '0;

        // ---- presses in RUN have no effect ----
        wr_cnt = 0;
        press(8, 8, k);
        press(8, 8, k);
        check("run_press_writes", 32'(wr_cnt),  32'd0);
        check("run_press_run",    32'(cpu_run), 32'd1);
        check("run_press_led",    32'(led),     32'(10'b1111111111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
